// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter states.
// Latency: n/a (types only).
// Backpressure: n/a.
package bp_types;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET = WNT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
// Latency: purely combinational.
// Backpressure: none, stateless.
module sat_counter2
    import bp_types::*;
(
    input  bht_state_t state,
    input  logic       taken,
    output bht_state_t next_state
);

    // Step one state towards ST on taken, towards SNT otherwise, sticking at the ends.
    always_comb begin
        next_state = state;
        case (state)
            SNT: next_state = taken ? WNT : SNT;
            WNT: next_state = taken ? WT  : SNT;
            WT:  next_state = taken ? ST  : WNT;
            ST:  next_state = taken ? ST  : WT;
            default: next_state = BHT_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direction predictor + BTB: fetch-side prediction, EX-side training, mispredict detect, perf counters.
// Latency: predictions and mispredict are combinational; table/counter updates visible next cycle.
// Backpressure: none; accepts one query and one resolving branch every cycle.
module branch_predictor
    import bp_types::*;
#(
    parameter int IDX_BITS = 5,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_br_en,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    bht_state_t          ctr    [ENTRIES];
    logic [ENTRIES-1:0]  valid;
    logic [TAG_BITS-1:0] tag    [ENTRIES];
    logic [31:0]         target [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic [TAG_BITS-1:0] ex_tag;
    logic [1:0]          if_ctr;
    logic                if_hit;
    bht_state_t          ctr_next;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    // Fetch-side lookup reads the current table state; a same-cycle write is not bypassed.
    assign if_ctr      = ctr[if_idx];
    assign if_hit      = valid[if_idx] && (tag[if_idx] == if_tag);
    assign pred_taken  = if_hit && if_ctr[1];
    assign pred_target = pred_taken ? target[if_idx] : if_pc + 32'd4;

    // A taken prediction with the wrong target is still a mispredict.
    assign mispredict  = ex_valid &&
                         ((ex_br_en != ex_pred_taken) ||
                          (ex_br_en && ex_pred_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_br_en ? ex_target : ex_pc + 32'd4;

    sat_counter2 u_sat_counter2 (
        .state      (ctr[ex_idx]),
        .taken      (ex_br_en),
        .next_state (ctr_next)
    );

    // Direction counters and valid bits; counters train without a tag check, so aliases share them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= BHT_RESET;
            end
            valid <= '0;
        end else if (ex_valid) begin
            ctr[ex_idx] <= ctr_next;
            if (ex_br_en) begin
                valid[ex_idx] <= 1'b1;
            end
        end
    end

    // BTB tag/target payload; contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && ex_valid && ex_br_en) begin
            tag[ex_idx]    <= ex_tag;
            target[ex_idx] <= ex_target;
        end
    end

    // Performance counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (ex_valid) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict) begin
                mispred_count <= mispred_count + 32'd1;
            end
        end
    end

endmodule
